// File: rtl/srt_result_fixup_if.sv
// rtl/srt_result_fixup_if.sv - digit/remainder input and Q/R result bundle of the SRT back-end stage
interface srt_result_fixup_if #(
  parameter int W  = 64,
  parameter int SW = 7
);
  // Set-up and digit stream from the SRT iteration core
  logic          start;
  logic [SW-1:0] shift;
  logic [W-1:0]  dsrn;
  logic          dig_vld;
  logic [1:0]    dig;
  logic          rem_vld;
  logic [W:0]    rem;
  // Result side
  logic          busy;
  logic          done;
  logic [W-1:0]  q;
  logic [W-1:0]  r;
  logic          err;

  modport master (
    output start, shift, dsrn, dig_vld, dig, rem_vld, rem,
    input  busy, done, q, r, err
  );

  modport slave (
    input  start, shift, dsrn, dig_vld, dig, rem_vld, rem,
    output busy, done, q, r, err
  );
endinterface

// File: rtl/srt_result_fixup.sv
// rtl/srt_result_fixup.sv - SRT divider back end: on-the-fly quotient conversion, remainder correction and de-normalisation
module srt_result_fixup #(
  parameter int W  = 64,
  parameter int SW = 7
) (
  input logic              clk,
  input logic              rst,
  srt_result_fixup_if.slave bus
);
  // Digit counter only needs to reach W; it saturates there so every extra digit keeps flagging
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    CORRECT = 3'd2,
    DENORM  = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] sh_cnt;
  logic [W-1:0]  dsrn_reg;
  logic [W-1:0]  q_acc;
  logic [W-1:0]  qm_acc;   // always q_acc - 1 modulo 2^W
  logic [CW-1:0] dig_cnt;
  logic          err_acc;
  logic [W:0]    rem_reg;
  logic [W-1:0]  q_res;
  logic [W-1:0]  r_acc;

  logic [W-1:0]  q_dig;
  logic [W-1:0]  qm_dig;
  logic          dig_bad;
  logic          rem_neg;
  logic [W-1:0]  q_cor;
  logic [W-1:0]  r_cor;

  // On-the-fly conversion: next Q/QM pair for the digit presented this cycle
  always_comb begin
    q_dig   = {q_acc[W-2:0], 1'b0};
    qm_dig  = {qm_acc[W-2:0], 1'b1};
    dig_bad = 1'b0;
    case (bus.dig)
      2'b01: begin
        q_dig  = {q_acc[W-2:0], 1'b1};
        qm_dig = {q_acc[W-2:0], 1'b0};
      end
      2'b11: begin
        q_dig  = {qm_acc[W-2:0], 1'b1};
        qm_dig = {qm_acc[W-2:0], 1'b0};
      end
      2'b10: begin
        // illegal code behaves as a zero digit but is reported
        dig_bad = 1'b1;
      end
      default: begin
        q_dig  = {q_acc[W-2:0], 1'b0};
        qm_dig = {qm_acc[W-2:0], 1'b1};
      end
    endcase
  end

  // Negative final remainder: take the decremented quotient and add the divisor back
  always_comb begin
    rem_neg = rem_reg[W];
    q_cor   = rem_neg ? qm_acc : q_acc;
    r_cor   = rem_neg ? (rem_reg[W-1:0] + dsrn_reg) : rem_reg[W-1:0];
  end

  // Control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh_cnt   <= '0;
      dsrn_reg <= '0;
      q_acc    <= '0;
      qm_acc   <= '1;
      dig_cnt  <= '0;
      err_acc  <= 1'b0;
      rem_reg  <= '0;
      q_res    <= '0;
      r_acc    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.err  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_cnt   <= bus.shift;
            dsrn_reg <= bus.dsrn;
            q_acc    <= '0;
            qm_acc   <= '1;
            dig_cnt  <= '0;
            err_acc  <= 1'b0;
            bus.busy <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.dig_vld) begin
            q_acc  <= q_dig;
            qm_acc <= qm_dig;
            if (dig_cnt != CNT_MAX) begin
              dig_cnt <= dig_cnt + 1'b1;
            end
            if (dig_bad || (dig_cnt == CNT_MAX)) begin
              err_acc <= 1'b1;
            end
          end
          // a digit arriving with the remainder is already folded into q_acc before CORRECT reads it
          if (bus.rem_vld) begin
            rem_reg <= bus.rem;
            state   <= CORRECT;
          end
        end
        CORRECT: begin
          q_res <= q_cor;
          r_acc <= r_cor;
          if (sh_cnt != '0) begin
            state <= DENORM;
          end else begin
            bus.done <= 1'b1;
            bus.q    <= q_cor;
            bus.r    <= r_cor;
            bus.err  <= err_acc;
            state    <= FIN;
          end
        end
        DENORM: begin
          r_acc  <= r_acc >> 1;
          sh_cnt <= sh_cnt - 1'b1;
          if (sh_cnt == SW'(1)) begin
            bus.done <= 1'b1;
            bus.q    <= q_res;
            bus.r    <= r_acc >> 1;
            bus.err  <= err_acc;
            state    <= FIN;
          end
        end
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
